// File: rtl/median_filter_stream.sv
// Streaming 3x3 median filter with internal line buffers, valid/ready handshake,
// border policy, bypass mode and an end-of-frame flush that drains the window.
module median_filter_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_sof,
  output logic              m_eol,
  input  logic              m_ready,
  input  logic              bypass,
  input  logic              border_zero,
  output logic              busy,
  output logic              err_sof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 3);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [FW-1:0] PAD_STEPS = FW'(IMG_W + 1);
  localparam logic [FW-1:0] STEP_LAST = FW'(IMG_W + 2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     col, cc;
  logic [RW-1:0]     row, cr;
  logic [FW-1:0]     fcnt;
  logic              rst_done, frame_bypass, frame_bzero;

  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] win [3][3];
  logic              v_win, border_w, sof_w, eol_w;

  logic [DATA_W-1:0] rmin [3];
  logic [DATA_W-1:0] rmed [3];
  logic [DATA_W-1:0] rmax [3];
  logic [DATA_W-1:0] centre_s1;
  logic              v_s1, border_s1, sof_s1, eol_s1;

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

  function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic              out_free, accept, flush_step, advance, centre_in, sof_start;
  logic [CW-1:0]     lb_addr, col_nx;
  logic [DATA_W-1:0] pix_in, med9, out_sel;

  assign out_free   = !m_valid || m_ready;
  assign s_ready    = rst_done && (state != FLUSH) && out_free;
  assign accept     = s_valid && s_ready;
  assign sof_start  = accept && s_sof && (state == IDLE);
  assign flush_step = (state == FLUSH) && out_free;
  assign advance    = sof_start || (accept && (state == FILL || state == RUN)) || flush_step;
  assign centre_in  = (state == RUN) || (state == FLUSH && fcnt < PAD_STEPS);
  assign lb_addr    = (state == IDLE) ? '0 : col;
  assign col_nx     = (col == COL_LAST) ? '0 : col + CW'(1);
  // Padding after the last pixel only ever reaches border outputs, which ignore it.
  assign pix_in     = (state == FLUSH) ? '0 : s_data;
  assign busy       = (state != IDLE);

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE:  if (sof_start) state_nx = FILL;
      FILL:  if (accept && row == RW'(1) && col == '0) state_nx = RUN;
      RUN:   if (accept && row == ROW_LAST && col == COL_LAST) state_nx = FLUSH;
      FLUSH: if (flush_step && fcnt == STEP_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rst_done     <= 1'b0;
      col          <= '0;
      row          <= '0;
      cc           <= '0;
      cr           <= '0;
      fcnt         <= '0;
      frame_bypass <= 1'b0;
      frame_bzero  <= 1'b0;
      err_sof      <= 1'b0;
    end else begin
      state    <= state_nx;
      rst_done <= 1'b1;
      if (accept && s_sof && (state == FILL || state == RUN)) err_sof <= 1'b1;
      if (sof_start) begin
        col          <= CW'(1);
        row          <= '0;
        cc           <= '0;
        cr           <= '0;
        fcnt         <= '0;
        frame_bypass <= bypass;
        frame_bzero  <= border_zero;
      end else if (advance) begin
        col <= col_nx;
        if (state != FLUSH && col == COL_LAST) row <= row + RW'(1);
        if (state == FLUSH) fcnt <= fcnt + FW'(1);
        if (state_nx == IDLE) row <= '0;
        if (centre_in) begin
          cc <= (cc == COL_LAST) ? '0 : cc + CW'(1);
          if (cc == COL_LAST) cr <= cr + RW'(1);
        end
      end
    end
  end

  // NOTE: line buffers, window and sort registers carry only data; they are not reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      lb1[lb_addr] <= lb0[lb_addr];
      lb0[lb_addr] <= pix_in;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[lb_addr];
      win[1][2] <= lb0[lb_addr];
      win[2][2] <= pix_in;
      for (int r = 0; r < 3; r++) begin
        rmin[r] <= min2(min2(win[r][0], win[r][1]), win[r][2]);
        rmed[r] <= med3(win[r][0], win[r][1], win[r][2]);
        rmax[r] <= max2(max2(win[r][0], win[r][1]), win[r][2]);
      end
      centre_s1 <= win[1][1];
    end
  end

  // Median of nine = median of (max of row minima, median of row medians, min of row maxima).
  assign med9 = med3(max2(max2(rmin[0], rmin[1]), rmin[2]),
                     med3(rmed[0], rmed[1], rmed[2]),
                     min2(min2(rmax[0], rmax[1]), rmax[2]));

  always_comb begin
    out_sel = med9;
    if (frame_bypass)     out_sel = centre_s1;
    else if (border_s1)   out_sel = frame_bzero ? '0 : centre_s1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_win     <= 1'b0;
      border_w  <= 1'b0;
      sof_w     <= 1'b0;
      eol_w     <= 1'b0;
      v_s1      <= 1'b0;
      border_s1 <= 1'b0;
      sof_s1    <= 1'b0;
      eol_s1    <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_sof     <= 1'b0;
      m_eol     <= 1'b0;
    end else if (advance) begin
      v_win     <= centre_in;
      border_w  <= (cr == '0) || (cr == ROW_LAST) || (cc == '0) || (cc == COL_LAST);
      sof_w     <= centre_in && (cr == '0) && (cc == '0);
      eol_w     <= centre_in && (cc == COL_LAST);
      v_s1      <= v_win;
      border_s1 <= border_w;
      sof_s1    <= sof_w;
      eol_s1    <= eol_w;
      m_valid   <= v_s1;
      m_data    <= out_sel;
      m_sof     <= v_s1 && sof_s1;
      m_eol     <= v_s1 && eol_s1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_median_filter_stream.sv
// Directed bench for median_filter_stream on a 4x4 image: median, border, bypass,
// backpressure, back-to-back frames, discarded pixels, sof errors and mid-frame reset.
module tb_median_filter_stream;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid, s_sof, s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid, m_sof, m_eol, m_ready;
  logic          bypass, border_zero, busy, err_sof;

  median_filter_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_ready(m_ready),
    .bypass(bypass), .border_zero(border_zero), .busy(busy), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // m_ready pattern 1,0,0,1 repeating when rdy_mode is set, else always ready.
  logic       rdy_mode = 1'b0;
  logic [3:0] rdy_pat  = 4'b1001;
  int         rdy_idx  = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode) begin
      m_ready = rdy_pat[rdy_idx];
      rdy_idx = (rdy_idx + 1) % 4;
    end else begin
      m_ready = 1'b1;
    end
  end

  logic [DW-1:0] out_q [$];
  bit            sof_q [$];
  bit            eol_q [$];
  bit            stalled = 0;
  logic [DW-1:0] held_data;
  logic [2:0]    held_flags;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stalled) begin
        check("hold_data", m_data, held_data);
        check("hold_flags", {m_valid, m_sof, m_eol}, held_flags);
      end
      if (m_valid && !m_ready) check("sready_stall", s_ready, 0);
      if (m_valid && m_ready) begin
        out_q.push_back(m_data);
        sof_q.push_back(m_sof);
        eol_q.push_back(m_eol);
      end
      stalled    = m_valid && !m_ready;
      held_data  = m_data;
      held_flags = {1'b1, m_sof, m_eol};
    end else begin
      stalled = 0;
    end
  end

  logic [DW-1:0] cur_frame [N];
  logic [DW-1:0] exp_frame [N];
  logic [DW-1:0] frame_a   [N];
  logic [DW-1:0] exp_norm  [N];
  logic [DW-1:0] exp_bz    [N];

  task automatic send_pixel(input logic [DW-1:0] d, input logic sof, output logic busy_seen);
    bit got = 0;
    busy_seen = 1'b0;
    s_data  = d;
    s_sof   = sof;
    s_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (s_ready) begin
        busy_seen = busy;
        got = 1;
        @(posedge clk);
        #1;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input int sof2_at, output logic first_busy);
    logic b;
    first_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      send_pixel(cur_frame[i], (i == 0) || (i == sof2_at), b);
      if (i == 0) first_busy = b;
      if (gaps && (i % 3 == 2)) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (!busy && !m_valid) done = 1;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    out_q.delete();
    sof_q.delete();
    eol_q.delete();
  endtask

  task automatic compare_frame(input string tag, input int base);
    for (int k = 0; k < N; k++) begin
      if (base + k < out_q.size()) begin
        check($sformatf("%s_data%0d", tag, k), out_q[base+k], exp_frame[k]);
        check($sformatf("%s_sof%0d", tag, k), sof_q[base+k], (k == 0));
        check($sformatf("%s_eol%0d", tag, k), eol_q[base+k], (k % W == W - 1));
      end
    end
  endtask

  logic fb;

  initial begin
    frame_a  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd90, 8'd0, 8'd60,
                 8'd70, 8'd80, 8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150};
    exp_norm = frame_a;
    exp_norm[5]  = 8'd50;
    exp_norm[6]  = 8'd60;
    exp_norm[9]  = 8'd90;
    exp_norm[10] = 8'd100;
    for (int i = 0; i < N; i++) exp_bz[i] = 8'd0;
    exp_bz[5]  = 8'd50;
    exp_bz[6]  = 8'd60;
    exp_bz[9]  = 8'd90;
    exp_bz[10] = 8'd100;

    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_sof = 1'b0;
    bypass = 1'b0; border_zero = 1'b0;
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err_sof", err_sof, 0);
    check("rst_s_ready", s_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain median frame.
    cur_frame = frame_a; exp_frame = exp_norm; clear_q();
    send_frame(0, -1, fb);
    wait_idle();
    check("med_count", out_q.size(), N);
    compare_frame("med", 0);
    check("med_busy_end", busy, 0);

    // Border zero.
    border_zero = 1'b1; exp_frame = exp_bz; clear_q();
    send_frame(0, -1, fb);
    wait_idle();
    check("bz_count", out_q.size(), N);
    compare_frame("bz", 0);

    // Bypass.
    border_zero = 1'b0; bypass = 1'b1; exp_frame = frame_a; clear_q();
    send_frame(0, -1, fb);
    wait_idle();
    check("byp_count", out_q.size(), N);
    compare_frame("byp", 0);
    bypass = 1'b0;

    // Backpressure with input gaps.
    exp_frame = exp_norm; clear_q(); rdy_idx = 0; rdy_mode = 1'b1;
    send_frame(1, -1, fb);
    wait_idle();
    rdy_mode = 1'b0;
    @(posedge clk); #1;
    check("bp_count", out_q.size(), N);
    compare_frame("bp", 0);

    // Two back-to-back constant frames.
    for (int i = 0; i < N; i++) begin
      cur_frame[i] = 8'hFF;
      exp_frame[i] = 8'hFF;
    end
    clear_q();
    send_frame(0, -1, fb);
    send_frame(0, -1, fb);
    check("b2b_second_sof_after_flush", fb, 0);
    wait_idle();
    check("b2b_count", out_q.size(), 2 * N);
    compare_frame("b2b0", 0);
    compare_frame("b2b1", N);

    // Pixels without sof in IDLE are dropped.
    clear_q();
    for (int i = 0; i < 3; i++) send_pixel(8'(i + 1), 1'b0, fb);
    repeat (10) @(posedge clk);
    #1;
    check("idle_drop_count", out_q.size(), 0);
    check("idle_drop_busy", busy, 0);
    check("err_sof_before", err_sof, 0);

    // Extra sof mid-frame.
    cur_frame = frame_a; exp_frame = exp_norm; clear_q();
    send_frame(0, 5, fb);
    check("err_sof_set", err_sof, 1);
    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    check("err_sof_sticky", err_sof, 1);
    check("sof2_count", out_q.size(), N);
    compare_frame("sof2", 0);

    // Reset in the middle of a frame.
    for (int i = 0; i < 7; i++) send_pixel(frame_a[i], (i == 0), fb);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_data", m_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err_sof", err_sof, 0);
    check("mid_rst_s_ready", s_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send_frame(0, -1, fb);
    wait_idle();
    check("post_rst_count", out_q.size(), N);
    compare_frame("post_rst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/median_filter_stream.md
Name: median_filter_stream

Overview:
- Streaming 3x3 median filter for raster video; next generation of the row-parallel median array.
- Adds internal line buffers and parametrised pixel width and image size.
- Adds valid/ready handshakes with backpressure, frame/line markers, border policy, bypass mode and end-of-frame flush.
- Sits between the pixel source and downstream processing; one pixel in and one pixel out per advance.

Parameters:
- DATA_W, 8, pixel width in bits (unsigned).
- IMG_W, 640, pixels per line (>=3).
- IMG_H, 480, lines per frame (>=3).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  input pixel.
- s_valid  in  1  input pixel valid.
- s_sof  in  1  marks first pixel of a frame; qualified by s_valid.
- s_ready  out  1  block accepts s_data this cycle.
- m_data  out  DATA_W  filtered pixel.
- m_valid  out  1  output valid.
- m_sof  out  1  first output pixel of frame.
- m_eol  out  1  last pixel of each output line.
- m_ready  in  1  downstream accepts.
- bypass  in  1  1 = output centre pixel instead of median.
- border_zero  in  1  1 = border pixels output 0; 0 = border pixels output centre pixel.
- busy  out  1  high in FILL/RUN/FLUSH.
- err_sof  out  1  sticky; set on s_sof accepted mid-frame; cleared only by reset.

Behaviour:
- Reset (async assert): state=IDLE, m_valid=0, m_data=0, m_sof=0, m_eol=0, busy=0, err_sof=0, s_ready=0, all counters 0. Line buffer RAM contents are not reset. Release is synchronous to clk; s_ready may rise on the first cycle after release.
- Accept occurs when s_valid && s_ready. s_ready = (state != FLUSH) && (!m_valid || m_ready).
- Advance = accept in FILL/RUN, or a flush step in FLUSH when (!m_valid || m_ready). The pipeline moves only on advance. m_data, m_valid, m_sof and m_eol hold stable while m_valid && !m_ready.
- FSM:
  - IDLE: accepted pixel without s_sof is discarded. Pixel with s_sof -> FILL; col=1, row=0; bypass and border_zero are latched for the frame.
  - FILL: accept pixels until IMG_W+1 pixels of the frame are in, then -> RUN. No output in FILL.
  - RUN: each accept produces one output (after pipeline latency). When the last pixel (IMG_W*IMG_H) is accepted -> FLUSH.
  - FLUSH: s_ready=0. IMG_W+1 flush steps emit the remaining outputs using don't-care padding; only border outputs depend on this padding. Then -> IDLE once the pipeline is empty.
- Window: two line buffers of IMG_W x DATA_W plus a 3x3 register window. Window centre = pixel (r,c); output is in raster order, exactly IMG_W*IMG_H pixels per frame.
- Median: exact 5th smallest of 9 unsigned values, computed by a sorting network registered in 2 stages (LAT=2 advances).
- Output k (raster index) becomes valid on the advance in which input k+IMG_W+1 (or the equivalent flush step) is taken, plus LAT advances.
- Border (r=0, r=IMG_H-1, c=0, c=IMG_W-1): output is 0 if border_zero, else the centre pixel. The median is never computed from out-of-image data.
- Bypass: output = centre pixel, with the same latency and markers.
- m_sof = 1 on output k=0; m_eol = 1 on output c=IMG_W-1.
- s_sof accepted in FILL/RUN: err_sof is set; the pixel is treated as an ordinary pixel and frame counters are not restarted.
- Back-to-back frames: the next frame's s_sof is accepted only after returning to IDLE (s_ready=0 during FLUSH).
- Line-wrap: col wraps IMG_W-1 -> 0 with row+1. row wraps to 0 only at IDLE entry.

Test Plan:
- IMG_W=4, IMG_H=4, border_zero=0, bypass=0, m_ready=1, frame rows {10 20 30 40 | 50 90 0 60 | 70 80 100 110 | 120 130 140 150} -> outputs equal inputs except (1,1)=50, (1,2)=60, (2,1)=90, (2,2)=100. m_sof on output 0, m_eol on outputs 3/7/11/15, exactly 16 outputs, then busy=0.
- Same frame with border_zero=1 -> 12 border outputs = 0, inner outputs 50/60/90/100. With bypass=1 instead -> outputs equal inputs in order.
- Same frame with m_ready toggled 1,0,0,1 repeating and s_valid gaps -> identical output sequence. No output changes while m_valid && !m_ready. s_ready=0 whenever m_valid && !m_ready.
- Constant frame of all 0xFF (DATA_W=8) followed immediately by a second frame with s_sof -> 32 outputs all 0xFF, two m_sof pulses, second frame's first pixel accepted only after FLUSH completes.
- Pixels without s_sof in IDLE -> discarded, no m_valid. Extra s_sof at pixel 5 -> err_sof=1 and stays 1, output count still 16.
- rst_n low during RUN after 7 pixels -> m_valid=0, busy=0, err_sof=0 immediately. A new frame after release produces a correct 16-pixel output.
